// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   NUM_COLS / NUM_ROWS : keypad matrix geometry
//   FRAME_W             : bits in one whole-keypad frame (bit n == key code n)
//   state_e             : report state machine encoding
//   popcount16, is_one_hot, onehot_to_idx : frame decoding helpers
package keypad_scanner_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int FRAME_W  = NUM_COLS * NUM_ROWS;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_e;

  // Number of pressed keys in a frame.
  function automatic logic [4:0] popcount16(input logic [FRAME_W-1:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      cnt = cnt + 5'(v[i]);
    end
    return cnt;
  endfunction

  function automatic logic is_one_hot(input logic [FRAME_W-1:0] v);
    return (popcount16(v) == 5'd1);
  endfunction

  // OR-encoder: only meaningful when v is one-hot, which the caller checks.
  function automatic logic [3:0] onehot_to_idx(input logic [FRAME_W-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      if (v[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous board inputs.
//   clk       : destination clock
//   rst_n     : asynchronous active-low reset (flops load RESET_VAL)
//   d [W]     : asynchronous input
//   q [W]     : synchronized output, two clocks of latency
module keypad_scanner_sync2 #(
  parameter int             W         = 4,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_d, meta_q;
  logic [W-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with whole-frame debounce.
//   clock          : system clock
//   reset          : asynchronous active-low reset
//   row [4]        : keypad rows, active-low, asynchronous
//   col [4]        : column drive, one-cold active-low, registered
//   keyCode [4]    : code of the last reported key, registered
//   keyValid       : one-cycle pulse in the cycle keyCode takes a new value;
//                    there is no back-pressure, a consumer must take it then
//   keyHeld        : report state (HELD) -- high while the reported key is down
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 2048,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [3:0]          keyCode,
  output logic                keyValid,
  output logic                keyHeld
);

  localparam int                  DIV_W    = $clog2(SCAN_DIV);
  localparam int                  CIDX_W   = $clog2(NUM_COLS);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]          DEB_MAX  = 4'(DEBOUNCE_SCANS);
  localparam logic [NUM_COLS-1:0] COL_ONE  = 1;

  logic [NUM_ROWS-1:0] row_sync;

  keypad_scanner_sync2 #(
    .W         (NUM_ROWS),
    .RESET_VAL ({NUM_ROWS{1'b1}})   // idle rows are pulled high
  ) u_row_sync (
    .clk   (clock),
    .rst_n (reset),
    .d     (row),
    .q     (row_sync)
  );

  logic [DIV_W-1:0]    div_d, div_q;
  logic [CIDX_W-1:0]   col_idx_d, col_idx_q;
  logic [NUM_COLS-1:0] col_d, col_q;
  logic [FRAME_W-1:0]  frame_d, frame_q;
  logic [FRAME_W-1:0]  prev_frame_d, prev_frame_q;
  logic [3:0]          stable_d, stable_q;
  state_e              state_d, state_q;
  logic [3:0]          key_code_d, key_code_q;
  logic                key_valid_d, key_valid_q;

  logic tick;
  logic frame_done;
  logic accept;

  always_comb begin
    div_d        = div_q + DIV_W'(1);   // power-of-two period: wraps by itself
    col_idx_d    = col_idx_q;
    frame_d      = frame_q;
    prev_frame_d = prev_frame_q;
    stable_d     = stable_q;
    state_d      = state_q;
    key_code_d   = key_code_q;
    key_valid_d  = 1'b0;

    // Sample on the last cycle of the column period so the rows have had the
    // whole period (minus synchronizer latency) to settle.
    tick       = (div_q == DIV_LAST);
    frame_done = tick && (col_idx_q == CIDX_W'(NUM_COLS - 1));

    if (tick) begin
      frame_d[col_idx_q * NUM_ROWS +: NUM_ROWS] = ~row_sync;
      col_idx_d = col_idx_q + CIDX_W'(1);
    end

    if (frame_done) begin
      if (frame_d == prev_frame_q) begin
        if (stable_q != DEB_MAX) stable_d = stable_q + 4'd1;
      end else begin
        stable_d     = 4'd1;
        prev_frame_d = frame_d;
      end
    end

    accept = frame_done && (stable_d == DEB_MAX);

    case (state_q)
      IDLE: begin
        if (accept && is_one_hot(frame_d)) begin
          key_code_d  = onehot_to_idx(frame_d);
          key_valid_d = 1'b1;
          state_d     = HELD;
        end
      end
      HELD: begin
        // Only a full release re-arms reporting; extra keys are ignored.
        if (accept && (frame_d == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    col_d = ~(COL_ONE << col_idx_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q        <= '0;
      col_idx_q    <= '0;
      col_q        <= ~COL_ONE;
      frame_q      <= '0;
      prev_frame_q <= '0;
      stable_q     <= '0;
      state_q      <= IDLE;
      key_code_q   <= '0;
      key_valid_q  <= 1'b0;
    end else begin
      div_q        <= div_d;
      col_idx_q    <= col_idx_d;
      col_q        <= col_d;
      frame_q      <= frame_d;
      prev_frame_q <= prev_frame_d;
      stable_q     <= stable_d;
      state_q      <= state_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
    end
  end

  assign col      = col_q;
  assign keyCode  = key_code_q;
  assign keyValid = key_valid_q;
  assign keyHeld  = (state_q == HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2
// (16-cycle frames). A keypad model turns key_mask into row levels.
module tb_keypad_scanner;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  keyCode;
  logic        keyValid;
  logic        keyHeld;

  logic [15:0] key_mask = '0;

  int total     = 0;
  int bad       = 0;
  int pulse_cnt = 0;
  int rd_idx    = 0;
  int base      = 0;

  logic [3:0] exp_q[$];
  logic [3:0] code_log[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout reached, bench did not finish");
    $fatal(1, "watchdog");
  end

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .keyCode  (keyCode),
    .keyValid (keyValid),
    .keyHeld  (keyHeld)
  );

  // Keypad matrix: key c*4+r pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (key_mask[c*4+r] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Pulse monitor: logs every reported code.
  always @(negedge clock) begin
    if (reset && keyValid) begin
      pulse_cnt <= pulse_cnt + 1;
      code_log.push_back(keyCode);
    end
  end

  // ---------------- driver / checking tasks ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Returns just after the edge on which col goes 0111 -> 1110.
  task automatic wait_frame_start();
    logic [3:0] prev;
    logic       found;
    prev  = col;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (prev == 4'b0111 && col == 4'b1110) found = 1'b1;
      prev = col;
    end
    check("frame_align", 16'(found), 16'd1);
  endtask

  task automatic drain_scoreboard();
    logic [3:0] e;
    while (rd_idx < code_log.size()) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("key_code", 16'(code_log[rd_idx]), 16'(e));
      end
      rd_idx++;
    end
  endtask

  task automatic release_and_idle();
    wait_frame_start();
    key_mask = 16'h0000;
    step(48);
    check("held_after_release", 16'(keyHeld), 16'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] exp_col;
    logic       found;

    // Reset values
    step(3);
    check("rst_col", 16'(col), 16'h000E);
    check("rst_code", 16'(keyCode), 16'h0000);
    check("rst_valid", 16'(keyValid), 16'd0);
    check("rst_held", 16'(keyHeld), 16'd0);

    // Idle scan: column walks every 4 cycles
    reset = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("col_scan", 16'(col), 16'(exp_col));
    end
    step(120);
    check("idle_code", 16'(keyCode), 16'h0000);
    check("idle_held", 16'(keyHeld), 16'd0);
    check("idle_pulses", 16'(pulse_cnt), 16'd0);

    // Key 5 held six frames then released
    base = pulse_cnt;
    wait_frame_start();
    exp_q.push_back(4'h5);
    key_mask = 16'h0020;
    step(31);
    check("k5_valid_early", 16'(keyValid), 16'd0);
    check("k5_held_early", 16'(keyHeld), 16'd0);
    step(1);
    check("k5_valid", 16'(keyValid), 16'd1);
    check("k5_code", 16'(keyCode), 16'h0005);
    check("k5_held", 16'(keyHeld), 16'd1);
    step(1);
    check("k5_valid_one_cycle", 16'(keyValid), 16'd0);
    step(63);
    check("k5_held_long", 16'(keyHeld), 16'd1);
    key_mask = 16'h0000;
    step(31);
    check("k5_held_before_release_accept", 16'(keyHeld), 16'd1);
    step(1);
    check("k5_held_fall", 16'(keyHeld), 16'd0);
    check("k5_code_hold", 16'(keyCode), 16'h0005);
    drain_scoreboard();
    check("k5_pulse_count", 16'(pulse_cnt - base), 16'd1);

    // Key 5 bouncing (toggle every 5 cycles) for 3 frames, then steady
    base = pulse_cnt;
    wait_frame_start();
    exp_q.push_back(4'h5);
    for (int i = 0; i < 48; i++) begin
      key_mask = (((i / 5) % 2) == 0) ? 16'h0020 : 16'h0000;
      step(1);
    end
    key_mask = 16'h0020;
    check("bounce_quiet", 16'(pulse_cnt - base), 16'd0);
    step(31);
    check("bounce_valid_early", 16'(keyValid), 16'd0);
    step(1);
    check("bounce_valid", 16'(keyValid), 16'd1);
    check("bounce_code", 16'(keyCode), 16'h0005);
    release_and_idle();
    drain_scoreboard();
    check("bounce_pulse_count", 16'(pulse_cnt - base), 16'd1);

    // Keys 2 and 7 together, then 7 released
    base = pulse_cnt;
    wait_frame_start();
    key_mask = 16'h0084;
    step(32);
    check("multi_held_a", 16'(keyHeld), 16'd0);
    check("multi_valid", 16'(keyValid), 16'd0);
    step(64);
    check("multi_held_b", 16'(keyHeld), 16'd0);
    check("multi_quiet", 16'(pulse_cnt - base), 16'd0);
    exp_q.push_back(4'h2);
    key_mask = 16'h0004;
    step(31);
    check("k2_valid_early", 16'(keyValid), 16'd0);
    step(1);
    check("k2_valid", 16'(keyValid), 16'd1);
    check("k2_code", 16'(keyCode), 16'h0002);
    check("k2_held", 16'(keyHeld), 16'd1);
    release_and_idle();
    drain_scoreboard();
    check("k2_pulse_count", 16'(pulse_cnt - base), 16'd1);

    // Key F held, key 3 added, full release, then key 3 alone
    base = pulse_cnt;
    wait_frame_start();
    exp_q.push_back(4'hF);
    key_mask = 16'h8000;
    step(32);
    check("kf_valid", 16'(keyValid), 16'd1);
    check("kf_code", 16'(keyCode), 16'h000F);
    step(16);
    key_mask = 16'h8008;
    step(64);
    check("kf3_held", 16'(keyHeld), 16'd1);
    check("kf3_code_kept", 16'(keyCode), 16'h000F);
    check("kf3_one_pulse", 16'(pulse_cnt - base), 16'd1);
    key_mask = 16'h0000;
    step(31);
    check("kf_held_pre_fall", 16'(keyHeld), 16'd1);
    step(1);
    check("kf_held_fall", 16'(keyHeld), 16'd0);
    step(16);
    exp_q.push_back(4'h3);
    key_mask = 16'h0008;
    step(31);
    check("k3_valid_early", 16'(keyValid), 16'd0);
    step(1);
    check("k3_valid", 16'(keyValid), 16'd1);
    check("k3_code", 16'(keyCode), 16'h0003);
    release_and_idle();
    drain_scoreboard();
    check("kf3_pulse_count", 16'(pulse_cnt - base), 16'd2);

    // Key 9 held, reset mid-frame, re-report after reset release
    base = pulse_cnt;
    wait_frame_start();
    exp_q.push_back(4'h9);
    key_mask = 16'h0200;
    step(32);
    check("k9_valid", 16'(keyValid), 16'd1);
    check("k9_code", 16'(keyCode), 16'h0009);
    step(8);
    reset = 1'b0;
    #1;
    check("midrst_col", 16'(col), 16'h000E);
    check("midrst_code", 16'(keyCode), 16'h0000);
    check("midrst_valid", 16'(keyValid), 16'd0);
    check("midrst_held", 16'(keyHeld), 16'd0);
    step(3);
    reset = 1'b1;
    exp_q.push_back(4'h9);
    found = 1'b0;
    for (int i = 0; i < 48 && !found; i++) begin
      step(1);
      if (keyValid) found = 1'b1;
    end
    check("k9_rereport", 16'(found), 16'd1);
    check("k9_rereport_code", 16'(keyCode), 16'h0009);
    release_and_idle();
    drain_scoreboard();
    check("k9_pulse_count", 16'(pulse_cnt - base), 16'd2);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart to the multiplexed seven-segment display driver: scans a 4x4 hex matrix keypad by driving one column low at a time, samples the four row lines, debounces whole-keypad frames and reports a single debounced key press as a 4-bit hex code with a one-cycle valid pulse. It sits beside the display driver on the board I/O and feeds key codes to the accelerator control logic and to the display value register.

## Interface
- SCAN_DIV, 2048: clock cycles each column is driven; must be ≥4 and a power of two.
- DEBOUNCE_SCANS, 4: consecutive identical full frames required before a frame is accepted; range 1–15.

- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- row  input  4  keypad row lines; active-low, pulled up off-chip; asynchronous to clock.
- col  output  4  keypad column drive; one-cold, active-low; registered.
- keyCode  output  4  hex code of the last accepted key; registered.
- keyValid  output  1  one-cycle pulse when keyCode updates.
- keyHeld  output  1  high while an accepted key remains pressed.

## Operation
- row passes through a two-flop synchronizer before any use.
- Divider counter, 0..SCAN_DIV-1, free-running. The terminal count is the column tick.
- Column index colIdx, 2 bits. col = ~(4'b0001 << colIdx).
- On each tick, the inverted synchronized row is written into frame bits [colIdx*4 +: 4], then colIdx increments modulo 4.
- Key code for frame bit n is n, so code = {colIdx, rowIdx}.
- Frame complete: the tick with colIdx==3. On that tick the assembled 16-bit frame is compared with prevFrame:
  - If equal: stableCnt increments, saturating at DEBOUNCE_SCANS.
  - If different: stableCnt=1 and prevFrame is updated.
  - With DEBOUNCE_SCANS=1, every frame counts as stable.
- Accept event: a frame-complete tick that leaves stableCnt == DEBOUNCE_SCANS.
- State machine:
  - IDLE:
    - Accepted frame with exactly one bit set: keyCode ← index of that bit, keyValid pulses, go to HELD.
    - Accepted frame with zero bits or with ≥2 bits set: no report, stay IDLE.
  - HELD:
    - Accepted all-zero frame: go to IDLE.
    - Any other accepted frame, including a different key or multiple keys: stay HELD, no pulse.
    - A new key is reported only after a full release.
- keyHeld = (state == HELD).
- Ghosting or multi-key frames never produce a code.

## Timing
- Reset values:
  - col = 4'b1110
  - keyCode = 4'h0
  - keyValid = 0
  - keyHeld = 0
  - divider, colIdx and stableCnt all 0; frame and prevFrame all 0; state IDLE.
- Reset is asserted asynchronously and released synchronously by the board-level reset conditioning. Reset mid-scan discards the partial frame and debounce history.
- Row sampling happens on the last cycle of each column period, so the line has SCAN_DIV-1 cycles to settle, which covers synchronizer latency.
- Frame period is 4·SCAN_DIV cycles.
- Press-to-keyValid latency depends on press alignment:
  - Minimum: DEBOUNCE_SCANS frames after the first frame fully containing the press.
  - Maximum: (DEBOUNCE_SCANS+1) frames after the first frame fully containing the press.
- keyValid and keyCode are registered and rise one clock after the accepting tick. keyCode holds its value until the next accept in IDLE.
- keyHeld falls one clock after the accepting release tick.
- Counter wrap: the divider and colIdx wrap naturally. stableCnt saturates and never wraps.
- Press and release inside one debounce window: frames differ, so stableCnt restarts and no report is made.

## Structure
- Shared package holds:
  - NUM_COLS=4, NUM_ROWS=4
  - state encoding: IDLE=1'b0, HELD=1'b1
  - the one-hot-to-index function for the 16-bit frame, plus the popcount/one-bit test
- Sub-module: sync2, a 4-bit two-flop synchronizer with async active-low reset. It is reused for other board inputs.
- Everything else stays in one module.

## Test plan
All scenarios run with SCAN_DIV=4 and DEBOUNCE_SCANS=2, giving a 16-cycle frame.
- Reset, then idle rows=4'hF for 10 frames:
  - col cycles 1110→1101→1011→0111 every 4 cycles.
  - keyValid is never asserted; keyCode=0; keyHeld=0.
- Hold key 5 (row[1] low only while col[1] low) for 6 frames, then release:
  - Exactly one keyValid pulse with keyCode=4'h5.
  - keyHeld is high from the pulse until 2–3 frames after release.
- Key 5 bouncing: toggle every 5 cycles for 3 frames, then hold steady:
  - No pulse during bouncing.
  - One pulse with code 4'h5 after the hold stabilises.
- Press key 2 and key 7 together for 6 frames:
  - No keyValid; keyHeld stays 0.
  - Then release 7 while holding 2: one pulse with code 4'h2.
- Press key F and hold it, then add key 3 without releasing:
  - One pulse with code 4'hF; no pulse for key 3.
  - After full release, pressing key 3 gives a pulse with code 4'h3.
- Assert reset mid-frame while key 9 is stable and held:
  - All outputs return to their reset values immediately.
  - After release of reset with key 9 still held, a new pulse with code 4'h9 follows within 3 frames.
